cachepool_boot_ctrl_responder: RTL and testbench
================================================

// Module: cachepool_boot_ctrl_responder
// PURPOSE
//  Cluster-side reqrsp responder for boot control: terminates the SoC-to-cluster reqrsp port
//  (behind axi_to_reqrsp) for the boot window. Holds the boot entry point, generates per-core
//  wake pulses and latches the end-of-computation code. Single outstanding response slot with
//  full q/p valid-ready handshakes.
// PARAMETERS
//  AddrWidth        48            request address width
//  DataWidth        32            data width (multiple of 8; >= 32)
//  NumCores         4             number of wake lines
//  BaseAddr         'h0           16-byte-aligned base of the 4-word register window
//  BootAddrRst      'h8000_0000   reset value of BOOT_CONTROL
//  WakePulseCycles  4             wake_o pulse length in cycles (>= 1)
// PORTS
//  clk_i        in   1                 clock
//  rst_ni       in   1                 asynchronous active-low reset
//  q_valid_i    in   1                 request valid
//  q_ready_o    out  1                 request ready
//  q_addr_i     in   AddrWidth         request byte address
//  q_write_i    in   1                 1 = write, 0 = read
//  q_data_i     in   DataWidth         write data
//  q_strb_i     in   DataWidth/8       byte write strobes
//  q_amo_i      in   4                 reqrsp_pkg amo_op_e; only AMONone is supported
//  p_valid_o    out  1                 response valid
//  p_ready_i    in   1                 response ready
//  p_data_o     out  DataWidth         read data (0 for writes)
//  p_error_o    out  1                 response error
//  boot_addr_o  out  32                current BOOT_CONTROL value
//  wake_o       out  NumCores          per-core wake pulses (debug_req style)
//  eoc_o        out  1                 end-of-computation flag
//  eoc_code_o   out  31                exit code latched with eoc_o
// BEHAVIOUR
//  - Map (offset = q_addr_i[3:2]; hit iff q_addr_i[AddrWidth-1:4] == BaseAddr[AddrWidth-1:4]):
//    0 BOOT_CONTROL rw, 1 WAKE wo (reads 0), 2 EOC rw {code[31:1], eoc[0]}, 3 unmapped.
//  - Unmapped access: miss, offset 3, or q_amo_i != AMONone.
//  - q_ready_o = !p_valid_o || p_ready_i. Accept on q_valid_i && q_ready_o.
//  - Accept latency: response registered; p_valid_o rises the cycle after accept.
//  - Back-to-back accepts sustain 1 req/cycle while p_ready_i stays high.
//  - p_data_o/p_error_o are held stable while p_valid_o && !p_ready_i.
//  - Writes honour q_strb_i per byte on bits [31:0]; strobes above bit 31 are ignored.
//  - Register updates take effect at the accept edge; reads return the pre-write value.
//  - WAKE write: mask = q_data_i[NumCores-1:0] (byte-strobed). wake_o <= wake_o | mask.
//    The counter loads WakePulseCycles and decrements each cycle; wake_o clears when it reaches 0.
//    A write while a pulse is active ORs in the mask and reloads the counter. mask 0 has no effect.
//  - EOC write: eoc_o <= data[0]; eoc_code_o <= data[31:1]. Sticky until the next write or reset.
//  - Reset values: q_ready_o=1, p_valid_o=0, p_data_o=0, p_error_o=0, boot_addr_o=BootAddrRst,
//    wake_o=0, eoc_o=0, eoc_code_o=0.
//  - Reset asserted mid-transaction drops any pending response. No response is replayed.
// CONFIGURATION
//  BOOT_CTRL_ERR_RESP_EN
//  - Defined: an unmapped access sets p_error_o=1 with p_data_o=0. Unmapped writes have no
//    register side effects.
//  - Undefined: p_error_o is tied 0. Unmapped reads return 0; unmapped writes are dropped silently.
//  - Handshake timing is identical in both builds.
// TESTING
//  1 Reset, then read offset 0 -> p_data_o=0x8000_0000, p_error_o=0, one cycle after accept.
//  2 Write 0x8000_3000 strb 0xF to offset 0, then read it back -> 0x8000_3000.
//    Then write 0xFFFF_FFFF strb 0x1 -> boot_addr_o=0x8000_30FF.
//  3 Write 0x5 to WAKE, NumCores=4, WakePulseCycles=4 -> wake_o=4'b0101 for exactly 4 cycles.
//    A write of 0x2 on the 3rd pulse cycle -> 4'b0111 for 4 further cycles.
//  4 p_ready_i held low 5 cycles with a pending response -> q_ready_o=0 and p_data_o stable.
//    A second q_valid_i stays unaccepted until p_ready_i rises.
//  5 Write 0x0000_0007 to EOC -> eoc_o=1, eoc_code_o=3. Read back returns 0x7.
//  6 Read offset 3 / AMOAdd to offset 0 -> p_error_o=1 with BOOT_CTRL_ERR_RESP_EN, else 0.
//    In both builds p_data_o=0 and boot_addr_o is unchanged.
//  7 Reset asserted while p_valid_o=1 -> p_valid_o=0 and all outputs at reset values immediately.

Source files
------------

// File: rtl/cachepool_boot_ctrl_responder_if.sv
// rtl/cachepool_boot_ctrl_responder_if.sv - reqrsp request/response channel bundle for the boot-control responder
interface cachepool_boot_ctrl_responder_if #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 32
);
  logic                   q_valid;
  logic                   q_ready;
  logic [AddrWidth-1:0]   q_addr;
  logic                   q_write;
  logic [DataWidth-1:0]   q_data;
  logic [DataWidth/8-1:0] q_strb;
  logic [3:0]             q_amo;
  logic                   p_valid;
  logic                   p_ready;
  logic [DataWidth-1:0]   p_data;
  logic                   p_error;

  modport master (
    output q_valid, q_addr, q_write, q_data, q_strb, q_amo, p_ready,
    input  q_ready, p_valid, p_data, p_error
  );

  modport slave (
    input  q_valid, q_addr, q_write, q_data, q_strb, q_amo, p_ready,
    output q_ready, p_valid, p_data, p_error
  );
endinterface

// File: rtl/cachepool_boot_ctrl_responder.sv
// rtl/cachepool_boot_ctrl_responder.sv - boot-control reqrsp responder: boot address, wake pulses, EOC code
// Optional macro BOOT_CTRL_ERR_RESP_EN: unmapped accesses answer with p_error set.
module cachepool_boot_ctrl_responder #(
  parameter int unsigned          AddrWidth       = 48,
  parameter int unsigned          DataWidth       = 32,
  parameter int unsigned          NumCores        = 4,
  parameter logic [AddrWidth-1:0] BaseAddr        = '0,
  parameter logic [31:0]          BootAddrRst     = 32'h8000_0000,
  parameter int unsigned          WakePulseCycles = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cachepool_boot_ctrl_responder_if.slave bus,
  output logic [31:0]           boot_addr_o,
  output logic [NumCores-1:0]   wake_o,
  output logic                  eoc_o,
  output logic [30:0]           eoc_code_o
);

  localparam logic [3:0]  AmoNone  = 4'h0;
  localparam int unsigned CntWidth = $clog2(WakePulseCycles + 1);

  typedef enum logic {
    RSP_IDLE,
    RSP_PEND
  } rsp_state_e;

  typedef enum logic [1:0] {
    REG_BOOT = 2'd0,
    REG_WAKE = 2'd1,
    REG_EOC  = 2'd2,
    REG_NONE = 2'd3
  } reg_off_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  rsp_state_e            state_q, state_d;
  reg_off_e              offset;
  logic                  accept;
  logic                  hit;
  logic                  mapped;
  logic [31:0]           rdata;
  logic [31:0]           boot_wdata;
  logic [31:0]           eoc_wdata;
  logic [31:0]           wake_wdata;
  logic [NumCores-1:0]   wake_mask;
  logic                  wake_set;
  logic [CntWidth-1:0]   wake_cnt_q;
  logic [DataWidth-1:0]  p_data_d, p_data_q;
  logic                  unused_bits;

  assign offset   = reg_off_e'(bus.q_addr[3:2]);
  assign hit      = (bus.q_addr[AddrWidth-1:4] == BaseAddr[AddrWidth-1:4]);
  assign mapped   = hit && (offset != REG_NONE) && (bus.q_amo == AmoNone);

  // One response slot: a new request may enter whenever the slot drains this cycle.
  assign bus.p_valid = (state_q == RSP_PEND);
  assign bus.q_ready = !bus.p_valid || bus.p_ready;
  assign accept      = bus.q_valid && bus.q_ready;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = RSP_PEND;
    end else if (bus.p_ready) begin
      state_d = RSP_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RSP_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    rdata = '0;
    if (mapped && !bus.q_write) begin
      case (offset)
        REG_BOOT: rdata = boot_addr_o;
        REG_EOC:  rdata = {eoc_code_o, eoc_o};
        default:  rdata = '0;
      endcase
    end
  end

  always_comb begin
    p_data_d        = '0;
    p_data_d[31:0]  = rdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     p_data_q <= '0;
    else if (accept) p_data_q <= p_data_d;
  end
  assign bus.p_data = p_data_q;

`ifdef BOOT_CTRL_ERR_RESP_EN
  logic p_error_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     p_error_q <= 1'b0;
    else if (accept) p_error_q <= !mapped;
  end
  assign bus.p_error = p_error_q;
`else
  assign bus.p_error = 1'b0;
`endif

  // Only the low 32 bits carry register content; wider strobes/data are ignored.
  assign boot_wdata = strb_merge(boot_addr_o, bus.q_data[31:0], bus.q_strb[3:0]);
  assign eoc_wdata  = strb_merge({eoc_code_o, eoc_o}, bus.q_data[31:0], bus.q_strb[3:0]);
  assign wake_wdata = strb_merge(32'h0, bus.q_data[31:0], bus.q_strb[3:0]);
  assign wake_mask  = wake_wdata[NumCores-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_addr_o <= BootAddrRst;
      eoc_o       <= 1'b0;
      eoc_code_o  <= '0;
    end else if (accept && bus.q_write && mapped) begin
      if (offset == REG_BOOT) boot_addr_o <= boot_wdata;
      if (offset == REG_EOC) begin
        eoc_o      <= eoc_wdata[0];
        eoc_code_o <= eoc_wdata[31:1];
      end
    end
  end

  assign wake_set = accept && bus.q_write && mapped && (offset == REG_WAKE) && (wake_mask != '0);

  // A fresh wake write extends the whole pulse: mask accumulates, counter restarts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wake_o     <= '0;
      wake_cnt_q <= '0;
    end else if (wake_set) begin
      wake_o     <= wake_o | wake_mask;
      wake_cnt_q <= CntWidth'(WakePulseCycles);
    end else if (wake_cnt_q != '0) begin
      wake_cnt_q <= wake_cnt_q - CntWidth'(1);
      if (wake_cnt_q == CntWidth'(1)) wake_o <= '0;
    end
  end

  assign unused_bits = ^{bus.q_addr[1:0], bus.q_data, bus.q_strb, wake_wdata};

endmodule

// File: tb/tb_cachepool_boot_ctrl_responder.sv
// tb/tb_cachepool_boot_ctrl_responder.sv - directed plus randomized bench against a register-level reference model
module tb_cachepool_boot_ctrl_responder;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned WP = 4;
  localparam logic [AW-1:0] BASE = '0;
`ifdef BOOT_CTRL_ERR_RESP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cachepool_boot_ctrl_responder_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

  logic [31:0]   boot_addr;
  logic [NC-1:0] wake;
  logic          eoc;
  logic [30:0]   eoc_code;

  cachepool_boot_ctrl_responder #(
    .AddrWidth(AW), .DataWidth(DW), .NumCores(NC), .BaseAddr(BASE),
    .BootAddrRst(32'h8000_0000), .WakePulseCycles(WP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .boot_addr_o(boot_addr), .wake_o(wake), .eoc_o(eoc), .eoc_code_o(eoc_code)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference state: register contents, response slot, wake mask with its expiry cycle.
  bit          m_pv;
  logic [31:0] m_pdata;
  bit          m_perr;
  logic [31:0] m_boot;
  logic [31:0] m_eoc;
  logic [NC-1:0] m_wmask;
  int          m_wend;
  int          cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_pv = 0; m_pdata = '0; m_perr = 0;
    m_boot = 32'h8000_0000; m_eoc = '0; m_wmask = '0; m_wend = 0;
  endtask

  task automatic check_outputs();
    check("p_valid", 64'(bus.p_valid), 64'(m_pv));
    check("p_data", 64'(bus.p_data), 64'(m_pdata));
    check("p_error", 64'(bus.p_error), 64'(m_perr));
    check("boot_addr", 64'(boot_addr), 64'(m_boot));
    check("wake", 64'(wake), 64'(m_wmask));
    check("eoc", 64'(eoc), 64'(m_eoc[0]));
    check("eoc_code", 64'(eoc_code), 64'(m_eoc[31:1]));
  endtask

  task automatic check_reset_values();
    check("rst_q_ready", 64'(bus.q_ready), 64'd1);
    check("rst_p_valid", 64'(bus.p_valid), 64'd0);
    check("rst_p_data", 64'(bus.p_data), 64'd0);
    check("rst_p_error", 64'(bus.p_error), 64'd0);
    check("rst_boot", 64'(boot_addr), 64'h8000_0000);
    check("rst_wake", 64'(wake), 64'd0);
    check("rst_eoc", 64'(eoc), 64'd0);
    check("rst_eoc_code", 64'(eoc_code), 64'd0);
  endtask

  task automatic cycle(input bit qv, input logic [AW-1:0] a, input bit w, input logic [31:0] d,
                       input logic [3:0] s, input logic [3:0] amo, input bit pr);
    bit acc, mapped, woke;
    logic [1:0] off;
    logic [31:0] rd, wm;
    bus.q_valid = qv; bus.q_addr = a; bus.q_write = w; bus.q_data = d;
    bus.q_strb = s; bus.q_amo = amo; bus.p_ready = pr;
    #1;
    check("q_ready", 64'(bus.q_ready), 64'(!m_pv || pr));
    acc = qv && (!m_pv || pr);
    @(posedge clk);
    #1;
    off = a[3:2];
    mapped = (a[AW-1:4] == BASE[AW-1:4]) && (off != 2'd3) && (amo == 4'd0);
    woke = 0;
    if (acc) begin
      rd = !mapped ? 32'h0 : (off == 2'd0) ? m_boot : (off == 2'd2) ? m_eoc : 32'h0;
      m_pv = 1; m_pdata = w ? 32'h0 : rd; m_perr = ErrEn && !mapped;
      if (w && mapped) begin
        if (off == 2'd0) m_boot = merge(m_boot, d, s);
        if (off == 2'd2) m_eoc = merge(m_eoc, d, s);
        if (off == 2'd1) begin
          wm = merge(32'h0, d, s);
          if (wm[NC-1:0] != '0) begin
            m_wmask = m_wmask | wm[NC-1:0];
            m_wend = cyc + WP;
            woke = 1;
          end
        end
      end
    end else if (pr) begin
      m_pv = 0;
    end
    if (!woke && cyc >= m_wend) m_wmask = '0;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input bit pr);
    cycle(0, BASE, 0, 32'h0, 4'h0, 4'h0, pr);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [31:0] held;
    int idx;
    cyc = 0;
    model_reset();
    bus.q_valid = 0; bus.q_addr = '0; bus.q_write = 0; bus.q_data = '0;
    bus.q_strb = '0; bus.q_amo = '0; bus.p_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1;

    // Boot read after reset
    cycle(1, BASE + 0, 0, 32'h0, 4'h0, 4'h0, 1);
    check("t1_data", 64'(bus.p_data), 64'h8000_0000);
    check("t1_valid", 64'(bus.p_valid), 64'd1);
    idle(1);

    // Boot write, readback, partial-strobe write
    cycle(1, BASE + 0, 1, 32'h8000_3000, 4'hF, 4'h0, 1);
    cycle(1, BASE + 0, 0, 32'h0, 4'h0, 4'h0, 1);
    check("t2_readback", 64'(bus.p_data), 64'h8000_3000);
    cycle(1, BASE + 0, 1, 32'hFFFF_FFFF, 4'h1, 4'h0, 1);
    check("t2_strb", 64'(boot_addr), 64'h8000_30FF);
    idle(1);

    // Wake pulse and extension on the third pulse cycle
    cycle(1, BASE + 4, 1, 32'h5, 4'hF, 4'h0, 1);
    check("t3_wake_on", 64'(wake), 64'h5);
    idle(1);
    idle(1);
    cycle(1, BASE + 4, 1, 32'h2, 4'hF, 4'h0, 1);
    check("t3_wake_ext", 64'(wake), 64'h7);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("t3_wake_hold", 64'(wake), 64'h7);
    end
    idle(1);
    check("t3_wake_off", 64'(wake), 64'h0);
    cycle(1, BASE + 4, 1, 32'h0, 4'hF, 4'h0, 1);
    check("t3_wake_zero", 64'(wake), 64'h0);
    idle(1);

    // Backpressure: second request waits while p_ready is low
    cycle(1, BASE + 0, 0, 32'h0, 4'h0, 4'h0, 0);
    held = bus.p_data;
    for (int i = 0; i < 5; i++) begin
      cycle(1, BASE + 8, 0, 32'h0, 4'h0, 4'h0, 0);
      check("t4_q_ready_low", 64'(bus.q_ready), 64'd0);
      check("t4_hold", 64'(bus.p_data), 64'(held));
    end
    cycle(1, BASE + 8, 0, 32'h0, 4'h0, 4'h0, 1);
    idle(1);

    // EOC write and readback
    cycle(1, BASE + 8, 1, 32'h0000_0007, 4'hF, 4'h0, 1);
    check("t5_eoc", 64'(eoc), 64'd1);
    check("t5_code", 64'(eoc_code), 64'd3);
    cycle(1, BASE + 8, 0, 32'h0, 4'h0, 4'h0, 1);
    check("t5_read", 64'(bus.p_data), 64'h7);

    // Unmapped offset and unsupported AMO
    cycle(1, BASE + 12, 0, 32'h0, 4'h0, 4'h0, 1);
    check("t6_off3_err", 64'(bus.p_error), 64'(ErrEn));
    check("t6_off3_data", 64'(bus.p_data), 64'd0);
    cycle(1, BASE + 0, 1, 32'h1234_5678, 4'hF, 4'h2, 1);
    check("t6_amo_err", 64'(bus.p_error), 64'(ErrEn));
    check("t6_amo_boot", 64'(boot_addr), 64'h8000_30FF);
    idle(1);

    // Reset while a response is pending
    cycle(1, BASE + 0, 0, 32'h0, 4'h0, 4'h0, 0);
    check("t7_pending", 64'(bus.p_valid), 64'd1);
    bus.q_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc++;
    idle(1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      idx = $urandom_range(0, 4);
      ra = (idx < 4) ? (BASE + AW'(idx * 4)) : (BASE + AW'(32'h20));
      cycle(($urandom_range(0, 9) < 7), ra, $urandom_range(0, 1) == 1, $urandom,
            4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0) ? 4'h2 : 4'h0,
            ($urandom_range(0, 3) != 0));
    end
    repeat (6) idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
